// File: rtl/tdm_channel_sequencer.sv
// TDM channel sequencer for the EEG AFE input multiplexer.
// One-hot break-before-make selects, ADC sample strobe and frame marker.
module tdm_channel_sequencer #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int GAP  = 1,
    parameter int CIW  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            RST_N,
    input  logic            en,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [DW-1:0]   dwell,
    output logic [N_CH-1:0] CH,
    output logic [CIW-1:0]  ch_idx,
    output logic            sample,
    output logic            frame_start,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_GAP
    } state_t;

    localparam int GW = 4;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            wrap_q, wrap_d;
    logic [CIW-1:0]  idx_q, idx_d;
    logic [N_CH-1:0] ch_q, ch_d;
    logic            sample_q, sample_d;
    logic            frame_q, frame_d;
    logic            busy_q, busy_d;

    logic            enter;
    logic            enter_frame;
    logic [CIW-1:0]  nxt;
    logic [DW-1:0]   dwell_len;

    function automatic logic [CIW-1:0] lowest_set(
        input logic [N_CH-1:0] m
    );
        logic [CIW-1:0] r;
        logic [CIW-1:0] b;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            b = CIW'(i);
            if (m[b]) r = b;
        end
        return r;
    endfunction

    // Scan downwards so the smallest cyclic distance above cur wins;
    // distance N_CH lands back on cur itself (single-channel mask).
    function automatic logic [CIW-1:0] next_set(
        input logic [N_CH-1:0] m,
        input logic [CIW-1:0]  cur
    );
        logic [CIW-1:0] r;
        logic [CIW-1:0] b;
        int             j;
        r = cur;
        for (int k = N_CH; k >= 1; k--) begin
            j = (int'(cur) + k) % N_CH;
            b = CIW'(j);
            if (m[b]) r = b;
        end
        return r;
    endfunction

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        wrap_d      = wrap_q;
        idx_d       = idx_q;
        enter       = 1'b0;
        enter_frame = 1'b0;
        nxt         = next_set(ch_mask, idx_q);
        dwell_len   = (dwell == '0) ? DW'(1) : dwell;

        unique case (state_q)
            S_IDLE: begin
                if (en && (ch_mask != '0)) begin
                    enter       = 1'b1;
                    enter_frame = 1'b1;
                    idx_d       = lowest_set(ch_mask);
                end
            end
            S_DWELL: begin
                if (cnt_q > DW'(1)) begin
                    cnt_d = cnt_q - DW'(1);
                end else if (!en || (ch_mask == '0)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    gap_d   = GW'(GAP);
                    idx_d   = nxt;
                    wrap_d  = (nxt <= idx_q);
                end else begin
                    enter       = 1'b1;
                    enter_frame = (nxt <= idx_q);
                    idx_d       = nxt;
                end
            end
            S_GAP: begin
                if (gap_q > GW'(1)) begin
                    gap_d = gap_q - GW'(1);
                end else if (!en) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    enter       = 1'b1;
                    enter_frame = wrap_q;
                    gap_d       = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter) begin
            state_d = S_DWELL;
            cnt_d   = dwell_len;
        end

        ch_d     = '0;
        if (state_d == S_DWELL) begin
            ch_d = {{(N_CH-1){1'b0}}, 1'b1} << idx_d;
        end
        sample_d = (state_d == S_DWELL) && (cnt_d == DW'(1));
        frame_d  = enter && enter_frame;
        busy_d   = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            wrap_q   <= 1'b0;
            idx_q    <= '0;
            ch_q     <= '0;
            sample_q <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            wrap_q   <= wrap_d;
            idx_q    <= idx_d;
            ch_q     <= ch_d;
            sample_q <= sample_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
        end
    end

    assign CH          = ch_q;
    assign ch_idx      = idx_q;
    assign sample      = sample_q;
    assign frame_start = frame_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tdm_channel_sequencer.sv
// Bench for tdm_channel_sequencer: a GAP=1 and a GAP=0 instance
// driven together and compared against a segment-queue model.
module tb_tdm_channel_sequencer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] mask  = '0;
    logic [7:0] dwell = '0;

    logic [3:0] ch_o  [2];
    logic [1:0] idx_o [2];
    logic       smp_o [2];
    logic       frm_o [2];
    logic       bsy_o [2];

    tdm_channel_sequencer #(.N_CH(4), .DW(8), .GAP(1)) u_g1 (
        .clk(clk), .RST_N(rst_n), .en(en), .ch_mask(mask),
        .dwell(dwell), .CH(ch_o[0]), .ch_idx(idx_o[0]),
        .sample(smp_o[0]), .frame_start(frm_o[0]), .busy(bsy_o[0])
    );

    tdm_channel_sequencer #(.N_CH(4), .DW(8), .GAP(0)) u_g0 (
        .clk(clk), .RST_N(rst_n), .en(en), .ch_mask(mask),
        .dwell(dwell), .CH(ch_o[1]), .ch_idx(idx_o[1]),
        .sample(smp_o[1]), .frame_start(frm_o[1]), .busy(bsy_o[1])
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ch;
        logic [1:0] idx;
        logic       smp;
        logic       frm;
        logic       bsy;
        logic       is_gap;
        logic [1:0] nxt;
        logic       wrap;
    } ent_t;

    ent_t cur [2];
    ent_t q0 [$];
    ent_t q1 [$];
    int   gapv [2];
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] prev_ch0 = '0;

    task automatic chk(input string tag, input int k,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] @%0t got %0h want %0h",
                     tag, k, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i[1:0];
        end
        return 2'd0;
    endfunction

    function automatic logic [1:0] next_ch(input logic [3:0] m,
                                           input logic [1:0] c);
        int j;
        for (int s = 1; s <= 4; s++) begin
            j = (int'(c) + s) % 4;
            if (m[j]) return j[1:0];
        end
        return c;
    endfunction

    task automatic push(input int k, input ent_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop(input int k);
        if (k == 0) cur[k] = q0.pop_front();
        else        cur[k] = q1.pop_front();
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic go_idle(input int k, input logic [1:0] keep);
        cur[k]     = '0;
        cur[k].idx = keep;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) go_idle(k, 2'd0);
    endtask

    // A channel visit: D dwell entries, sample on last, frame on first.
    task automatic start(input int k, input logic [1:0] c,
                         input logic f);
        int   d;
        ent_t e;
        d = (dwell == 0) ? 1 : int'(dwell);
        for (int j = 0; j < d; j++) begin
            e     = '0;
            e.ch  = 4'(1) << c;
            e.idx = c;
            e.smp = (j == d - 1);
            e.frm = f && (j == 0);
            e.bsy = 1'b1;
            push(k, e);
        end
        pop(k);
    endtask

    // Predict the outputs after the coming rising edge.
    task automatic step(input int k);
        logic [1:0] n;
        logic       w;
        ent_t       e;
        if (qsize(k) > 0) begin
            pop(k);
        end else if (!cur[k].bsy) begin
            if (en && mask != 0) start(k, lowest(mask), 1'b1);
            else                 go_idle(k, cur[k].idx);
        end else if (!cur[k].is_gap) begin
            n = next_ch(mask, cur[k].idx);
            w = (n <= cur[k].idx);
            if (!en || mask == 0) begin
                go_idle(k, cur[k].idx);
            end else if (gapv[k] > 0) begin
                for (int g = 0; g < gapv[k]; g++) begin
                    e        = '0;
                    e.idx    = n;
                    e.bsy    = 1'b1;
                    e.is_gap = 1'b1;
                    e.nxt    = n;
                    e.wrap   = w;
                    push(k, e);
                end
                pop(k);
            end else begin
                start(k, n, w);
            end
        end else begin
            if (!en) go_idle(k, cur[k].idx);
            else     start(k, cur[k].nxt, cur[k].wrap);
        end
    endtask

    task automatic check_outputs(input int k);
        chk("ch", k, 32'(ch_o[k]), 32'(cur[k].ch));
        chk("ch_idx", k, 32'(idx_o[k]), 32'(cur[k].idx));
        chk("sample", k, 32'(smp_o[k]), 32'(cur[k].smp));
        chk("frame_start", k, 32'(frm_o[k]), 32'(cur[k].frm));
        chk("busy", k, 32'(bsy_o[k]), 32'(cur[k].bsy));
        chk("onehot0", k, 32'($onehot0(ch_o[k])), 32'd1);
    endtask

    task automatic check_zero(input int k);
        chk("rst_ch", k, 32'(ch_o[k]), 32'd0);
        chk("rst_idx", k, 32'(idx_o[k]), 32'd0);
        chk("rst_sample", k, 32'(smp_o[k]), 32'd0);
        chk("rst_frame", k, 32'(frm_o[k]), 32'd0);
        chk("rst_busy", k, 32'(bsy_o[k]), 32'd0);
    endtask

    initial begin
        bit do_rst;
        gapv[0] = 1;
        gapv[1] = 0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_zero(k);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 2; k++) check_outputs(k);
            if (prev_ch0 != 0 && ch_o[0] != 0)
                chk("bbm", 0, 32'(ch_o[0]), 32'(prev_ch0));
            prev_ch0 = ch_o[0];

            do_rst = 1'b0;
            if (cyc < 60) begin
                en = 1'b1; mask = 4'b1111; dwell = 8'd3;
                do_rst = (cyc == 30);
            end else if (cyc < 100) begin
                mask = 4'b1010; dwell = 8'd2;
            end else if (cyc < 140) begin
                mask = 4'b0100; dwell = 8'd4;
            end else if (cyc < 180) begin
                mask = 4'b1111;
                dwell = (cyc < 160) ? 8'd0 : 8'd5;
            end else if (cyc < 200) begin
                dwell = 8'd4;
                en = (cyc < 186);
            end else if (cyc < 215) begin
                en = 1'b1;
                mask = (cyc < 207) ? 4'b0110 : 4'b0000;
            end else begin
                if ($urandom_range(0, 7) == 0)
                    dwell = 8'($urandom_range(0, 5));
                if ($urandom_range(0, 15) == 0)
                    mask = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 23) == 0)
                    en = ~en;
                do_rst = ($urandom_range(0, 149) == 0);
            end

            if (do_rst) begin
                #3 rst_n = 1'b0;
                #1;
                for (int k = 0; k < 2; k++) check_zero(k);
                model_reset();
                prev_ch0 = '0;
            end else begin
                for (int k = 0; k < 2; k++) step(k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
